gate_delay_monitor: RTL and testbench

- Clocked measurement harness for the behavioural logic cells in the analog-core CPU model (nor/nand/inv with delay and jitter).
- Drives a stimulus edge into a cell input and waits for the cell output to respond with the expected polarity.
- Measures the response delay in clock cycles and accumulates min, max and sum over a programmed number of samples.
- Used in analog-core testbenches to check cell delay and jitter parameters against a fast reference clock.

---
 rtl/gate_delay_monitor.sv | 177 +++++++++++++++++
 tb/tb_gate_delay_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_delay_monitor.sv
// gate_delay_monitor
//   Clocked measurement harness for behavioural logic cells. Each sample
//   toggles stim_out into the cell input, then counts clock edges until the
//   synchronised cell output shows the expected polarity. Per-run min, max
//   and saturating sum of the measured delays are kept for readout.
//
// Ports
//   clk          measurement clock
//   rstb         asynchronous active-low reset
//   start        begin a run (sampled only in IDLE)
//   n_samp       number of edges to measure, captured at start
//   resp_in      cell output, asynchronous to clk
//   stim_out     drives the cell input
//   busy         high in any state other than IDLE
//   done         one-cycle pulse at the end of a run
//   timeout_err  set when a sample timed out; cleared at the next start
//   samp_cnt     completed samples in the current/last run
//   dly_min      smallest recorded delay (all ones if none)
//   dly_max      largest recorded delay
//   dly_sum      saturating sum of recorded delays
//
// State | meaning
// IDLE  | waiting for start; statistics hold their last values
// WAIT  | stimulus edge issued, counting until the response matches
// GAP   | one cycle between samples; decides next edge or end of run
// FIN   | one cycle with done asserted, then back to IDLE
module gate_delay_monitor #(
  parameter int N_CNT    = 12,
  parameter int N_ACC    = 20,
  parameter int N_SAMP_W = 8,
  parameter int TIMEOUT  = 1000,
  parameter bit INV      = 1'b1
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic [N_SAMP_W-1:0] n_samp,
  input  logic                resp_in,
  output logic                stim_out,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [N_SAMP_W-1:0] samp_cnt,
  output logic [N_CNT-1:0]    dly_min,
  output logic [N_CNT-1:0]    dly_max,
  output logic [N_ACC-1:0]    dly_sum
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_FIN} state_t;

  // Sum is formed wide enough to hold both operands plus a carry so the
  // saturation test cannot be fooled when N_ACC is narrower than N_CNT.
  localparam int W_SUM = ((N_ACC > N_CNT) ? N_ACC : N_CNT) + 1;
  localparam logic [N_CNT-1:0] CNT_ONES = {N_CNT{1'b1}};
  localparam logic [N_ACC-1:0] ACC_MAX  = {N_ACC{1'b1}};
  localparam logic [N_CNT-1:0] TO_CNT   = N_CNT'(TIMEOUT);

  state_t              r_state;
  logic [1:0]          r_sync;
  logic                r_stim;
  logic                r_busy;
  logic                r_done;
  logic                r_terr;
  logic [N_SAMP_W-1:0] r_nsamp;
  logic [N_SAMP_W-1:0] r_samp;
  logic [N_CNT-1:0]    r_cnt;
  logic [N_CNT-1:0]    r_min;
  logic [N_CNT-1:0]    r_max;
  logic [N_ACC-1:0]    r_sum;

  logic                w_resp_s;
  logic                w_exp;
  logic                w_match;
  logic [N_CNT-1:0]    w_cnt_nxt;
  logic [W_SUM-1:0]    w_sum_wide;
  logic [N_ACC-1:0]    w_sum_sat;

  // Two-flop synchroniser; its latency is part of every measured delay.
  // Reset to INV so an idle inverting cell (stim 0 -> resp 1) looks settled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync <= {2{INV}};
    end else begin
      r_sync <= {r_sync[0], resp_in};
    end
  end

  assign w_resp_s   = r_sync[1];
  assign w_exp      = r_stim ^ INV;
  assign w_match    = (w_resp_s == w_exp);
  assign w_cnt_nxt  = r_cnt + N_CNT'(1);
  assign w_sum_wide = W_SUM'(r_sum) + W_SUM'(w_cnt_nxt);
  assign w_sum_sat  = (w_sum_wide > W_SUM'(ACC_MAX)) ? ACC_MAX
                                                     : w_sum_wide[N_ACC-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_stim  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_terr  <= 1'b0;
      r_nsamp <= '0;
      r_samp  <= '0;
      r_cnt   <= '0;
      r_min   <= CNT_ONES;
      r_max   <= '0;
      r_sum   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_samp  <= '0;
            r_min   <= CNT_ONES;
            r_max   <= '0;
            r_sum   <= '0;
            r_terr  <= 1'b0;
            r_nsamp <= n_samp;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (n_samp != '0) begin
              r_stim  <= ~r_stim;
              r_state <= S_WAIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          // A match on the timeout edge is still recorded.
          if (w_match) begin
            if (w_cnt_nxt < r_min) r_min <= w_cnt_nxt;
            if (w_cnt_nxt > r_max) r_max <= w_cnt_nxt;
            r_sum   <= w_sum_sat;
            r_samp  <= r_samp + N_SAMP_W'(1);
            r_state <= S_GAP;
          end else if (w_cnt_nxt == TO_CNT) begin
            r_terr  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_GAP: begin
          if (r_samp == r_nsamp) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_stim  <= ~r_stim;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stim_out    = r_stim;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_terr;
  assign samp_cnt    = r_samp;
  assign dly_min     = r_min;
  assign dly_max     = r_max;
  assign dly_sum     = r_sum;

endmodule

// File: tb/tb_gate_delay_monitor.sv
// tb_gate_delay_monitor
//   Drives gate_delay_monitor against a behavioural inverting cell whose
//   delay (in whole clock periods) is chosen per stimulus edge from a table.
//   Expected run results are queued when a run is issued and checked by a
//   separate monitor whenever done pulses.
module tb_gate_delay_monitor;
  localparam int N_CNT    = 12;
  localparam int N_ACC    = 8;
  localparam int N_SAMP_W = 8;
  localparam int TIMEOUT  = 1000;

  logic                clk = 1'b0;
  logic                rstb = 1'b0;
  logic                start = 1'b0;
  logic [N_SAMP_W-1:0] n_samp = '0;
  logic                resp_in;
  logic                stim_out;
  logic                busy;
  logic                done;
  logic                timeout_err;
  logic [N_SAMP_W-1:0] samp_cnt;
  logic [N_CNT-1:0]    dly_min;
  logic [N_CNT-1:0]    dly_max;
  logic [N_ACC-1:0]    dly_sum;

  gate_delay_monitor #(
    .N_CNT(N_CNT), .N_ACC(N_ACC), .N_SAMP_W(N_SAMP_W),
    .TIMEOUT(TIMEOUT), .INV(1'b1)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .n_samp(n_samp),
    .resp_in(resp_in), .stim_out(stim_out), .busy(busy), .done(done),
    .timeout_err(timeout_err), .samp_cnt(samp_cnt), .dly_min(dly_min),
    .dly_max(dly_max), .dly_sum(dly_sum)
  );

  always #5 clk = ~clk;

  // Cell model: inverting, delay of cur_j clock periods per edge.
  int         dly_tab [256];
  int         tog_idx = 0;
  int         cur_j = 0;
  bit         stuck = 1'b0;
  logic [7:0] tb_sr = '0;

  always @(posedge clk) tb_sr <= {tb_sr[6:0], stim_out};

  always @(stim_out) begin
    cur_j = dly_tab[tog_idx];
    if (tog_idx < 255) tog_idx++;
  end

  assign resp_in = stuck ? 1'b1 : ~((cur_j == 0) ? stim_out : tb_sr[cur_j-1]);

  typedef struct {
    int tag;
    int samp;
    int mn;
    int mx;
    int sum;
    int terr;
    int stim;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_stim = 0;

  task automatic chk(input string nm, input int tag,
                     input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s run%0d actual=%0h required=%0h", nm, tag, act, req);
    end
  endtask

  // Monitor: consume one expected record per done pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      chk("done_width", 0, {31'd0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = sb_q.pop_front();
        chk("samp_cnt",    e.tag, 32'(samp_cnt),    32'(e.samp));
        chk("dly_min",     e.tag, 32'(dly_min),     32'(e.mn));
        chk("dly_max",     e.tag, 32'(dly_max),     32'(e.mx));
        chk("dly_sum",     e.tag, 32'(dly_sum),     32'(e.sum));
        chk("timeout_err", e.tag, 32'(timeout_err), 32'(e.terr));
        chk("stim_out",    e.tag, 32'(stim_out),    32'(e.stim));
      end
    end
    prev_done <= done;
  end

  // mode 0: fixed delay j on every edge, 1: random delay 0..4, 2: stuck at 1
  task automatic run_cell(input int tag, input int n, input int mode,
                          input int j, output int busy_cyc);
    exp_t e;
    int   d;
    bit   got;
    e.tag = tag; e.mn = 'hFFF; e.mx = 0; e.sum = 0;
    for (int k = 0; k < n; k++)
      dly_tab[k] = (mode == 1) ? int'($urandom_range(0, 4)) : j;
    if (mode == 2) begin
      e.samp = 0;
      e.terr = 1;
      if (n > 0) exp_stim = 1 - exp_stim;
    end else begin
      for (int k = 0; k < n; k++) begin
        d = 3 + dly_tab[k];
        if (d < e.mn) e.mn = d;
        if (d > e.mx) e.mx = d;
        e.sum = (e.sum + d > 255) ? 255 : e.sum + d;
      end
      e.samp = n;
      e.terr = 0;
      if (n % 2 == 1) exp_stim = 1 - exp_stim;
    end
    e.stim = exp_stim;
    tog_idx = 0;
    stuck = (mode == 2);
    sb_q.push_back(e);
    @(negedge clk);
    n_samp = N_SAMP_W'(n);
    start = 1'b1;
    got = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL run_timeout run%0d actual=no_done required=done", tag);
    end
    @(negedge clk);
    chk("busy_after", tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int  bc;
    bit  seen;
    for (int k = 0; k < 256; k++) dly_tab[k] = 0;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stim",  0, 32'(stim_out),    32'd0);
    chk("rst_busy",  0, 32'(busy),        32'd0);
    chk("rst_done",  0, 32'(done),        32'd0);
    chk("rst_terr",  0, 32'(timeout_err), 32'd0);
    chk("rst_samp",  0, 32'(samp_cnt),    32'd0);
    chk("rst_min",   0, 32'(dly_min),     32'hFFF);
    chk("rst_max",   0, 32'(dly_max),     32'd0);
    chk("rst_sum",   0, 32'(dly_sum),     32'd0);
    rstb = 1'b1;
    repeat (10) @(negedge clk);

    run_cell(1, 4, 0, 0, bc);   // zero-delay loopback: d=3 each, sum 12
    run_cell(2, 8, 0, 5, bc);   // 5-period cell: d=8 each, sum 64
    run_cell(3, 0, 0, 0, bc);   // empty run: stats at reset values
    run_cell(4, 1, 2, 0, bc);   // stuck response: timeout
    total++;
    if (bc < 999 || bc > 1003) begin
      bad++;
      $display("FAIL busy_cycles run4 actual=%0d required=999..1003", bc);
    end
    stuck = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during the third sample's WAIT.
    for (int k = 0; k < 4; k++) dly_tab[k] = 5;
    tog_idx = 0;
    @(negedge clk);
    n_samp = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (samp_cnt == 8'd2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_samp2", 5, {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("mid_stim", 5, 32'(stim_out),    32'd0);
    chk("mid_busy", 5, 32'(busy),        32'd0);
    chk("mid_done", 5, 32'(done),        32'd0);
    chk("mid_samp", 5, 32'(samp_cnt),    32'd0);
    chk("mid_min",  5, 32'(dly_min),     32'hFFF);
    chk("mid_max",  5, 32'(dly_max),     32'd0);
    chk("mid_sum",  5, 32'(dly_sum),     32'd0);
    chk("mid_terr", 5, 32'(timeout_err), 32'd0);
    exp_stim = 0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (12) @(negedge clk);

    run_cell(6, 2, 0, 0, bc);   // normal run after reset: sum 6
    run_cell(7, 200, 1, 0, bc); // jittered cell: sum saturates at 255

    chk("queue_empty", 0, 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
